// File: rtl/scan_test_controller.sv
// On-chip scan-test sequencer: accepts patterns over valid/ready, shifts them into CHAINS chains
// while unloading and checking the previous response, then reports pass/fail statistics.
module scan_test_controller #(
  parameter int unsigned CHAINS       = 4,
  parameter int unsigned LEN          = 16,
  parameter int unsigned PI_W         = 17,
  parameter int unsigned PO_W         = 27,
  parameter int unsigned CNT_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic                  pat_last,
  input  logic [PI_W-1:0]       pat_pi,
  input  logic [CHAINS*LEN-1:0] pat_si,
  input  logic [PO_W-1:0]       pat_exp_po,
  input  logic [PO_W-1:0]       pat_po_mask,
  input  logic [CHAINS*LEN-1:0] pat_exp_so,
  input  logic [CHAINS*LEN-1:0] pat_so_mask,
  output logic                  scan_en,
  output logic [CHAINS-1:0]     scan_in,
  input  logic [CHAINS-1:0]     scan_out,
  output logic [PI_W-1:0]       dut_pi,
  input  logic [PO_W-1:0]       dut_po,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_W-1:0]      mismatch_cnt,
  output logic [CNT_W-1:0]      pattern_cnt,
  output logic [CNT_W-1:0]      first_fail_pat
);

  localparam int unsigned SW = CHAINS * LEN;
  localparam int unsigned KW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_CAPTURE, S_FLUSH, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  // current slot: drives the chains and capture
  logic [PI_W-1:0]    pi_q, pi_d;
  logic [SW-1:0]      si_q, si_d;
  logic [PO_W-1:0]    exp_po_q, exp_po_d, po_mask_q, po_mask_d;
  logic               last_q, last_d;
  // pending slot holds this pattern's expected response until it is unloaded
  logic [SW-1:0]      pend_exp_q, pend_exp_d, pend_mask_q, pend_mask_d;
  logic               pend_vld_q, pend_vld_d;
  logic [SW-1:0]      cmp_exp_q, cmp_exp_d, cmp_mask_q, cmp_mask_d;
  logic               cmp_vld_q, cmp_vld_d;

  logic               scan_en_q, scan_en_d, pat_ready_q, pat_ready_d;
  logic [CHAINS-1:0]  scan_in_q, scan_in_d;
  logic [PI_W-1:0]    dut_pi_q, dut_pi_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d, pat_cnt_q, pat_cnt_d, ffp_q, ffp_d;

  logic               so_mm_c, po_mm_c, mm_c;
  logic [CNT_W-1:0]   fail_idx_c;

  function automatic logic bit_at(input logic [SW-1:0] v, input int unsigned c,
                                  input logic [KW-1:0] k);
    logic [LEN-1:0] seg;
    seg = v[c*LEN +: LEN];
    return seg[k];
  endfunction

  // Per-cycle compare of scan-out (shift/flush) or POs (capture)
  always_comb begin
    so_mm_c = 1'b0;
    if ((state_q == S_SHIFT || state_q == S_FLUSH) && cmp_vld_q) begin
      for (int unsigned c = 0; c < CHAINS; c++) begin
        so_mm_c = so_mm_c | (bit_at(cmp_mask_q, c, k_q) & (scan_out[c] ^ bit_at(cmp_exp_q, c, k_q)));
      end
    end
    po_mm_c    = (state_q == S_CAPTURE) && (|((dut_po ^ exp_po_q) & po_mask_q));
    mm_c       = so_mm_c | po_mm_c;
    fail_idx_c = (state_q == S_CAPTURE) ? pat_cnt_q : pat_cnt_q - CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pi_d        = pi_q;
    si_d        = si_q;
    exp_po_d    = exp_po_q;
    po_mask_d   = po_mask_q;
    last_d      = last_q;
    pend_exp_d  = pend_exp_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    cmp_exp_d   = cmp_exp_q;
    cmp_mask_d  = cmp_mask_q;
    cmp_vld_d   = cmp_vld_q;
    dut_pi_d    = dut_pi_q;
    done_d      = done_q;
    fail_d      = fail_q;
    mm_cnt_d    = mm_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    ffp_d       = ffp_q;
    scan_en_d   = 1'b0;
    scan_in_d   = '0;
    pat_ready_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          fail_d     = 1'b0;
          done_d     = 1'b0;
          mm_cnt_d   = '0;
          pat_cnt_d  = '0;
          ffp_d      = '0;
          pend_vld_d = 1'b0;
          cmp_vld_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (pat_valid) begin
          pi_d        = pat_pi;
          si_d        = pat_si;
          exp_po_d    = pat_exp_po;
          po_mask_d   = pat_po_mask;
          last_d      = pat_last;
          cmp_exp_d   = pend_exp_q;
          cmp_mask_d  = pend_mask_q;
          cmp_vld_d   = pend_vld_q;
          pend_exp_d  = pat_exp_so;
          pend_mask_d = pat_so_mask;
          pend_vld_d  = 1'b1;
          k_d         = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (k_q == K_LAST) state_d = S_CAPTURE;
        else               k_d     = k_q + KW'(1);
      end
      S_CAPTURE: begin
        pat_cnt_d = pat_cnt_q + CNT_W'(1);
        if (last_q) begin
          state_d    = S_FLUSH;
          k_d        = '0;
          cmp_exp_d  = pend_exp_q;
          cmp_mask_d = pend_mask_q;
          cmp_vld_d  = pend_vld_q;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        if (k_q == K_LAST) state_d = S_DONE;
        else               k_d     = k_q + KW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mm_c) begin
      fail_d = 1'b1;
      if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + CNT_W'(1);
      if (!fail_q) ffp_d = fail_idx_c;
      if (STOP_ON_FAIL) state_d = S_DONE;
    end

    // Outputs are registered, so decode them from the state being entered
    scan_en_d   = (state_d == S_SHIFT) || (state_d == S_FLUSH);
    pat_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d == S_LOAD) || (state_d == S_SHIFT) ||
                  (state_d == S_CAPTURE) || (state_d == S_FLUSH);
    if (state_d == S_DONE)    done_d   = 1'b1;
    if (state_d == S_CAPTURE) dut_pi_d = pi_d;
    if (state_d == S_SHIFT) begin
      for (int unsigned c = 0; c < CHAINS; c++) scan_in_d[c] = bit_at(si_d, c, k_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      pi_q        <= '0;
      si_q        <= '0;
      exp_po_q    <= '0;
      po_mask_q   <= '0;
      last_q      <= 1'b0;
      pend_exp_q  <= '0;
      pend_mask_q <= '0;
      pend_vld_q  <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_mask_q  <= '0;
      cmp_vld_q   <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= '0;
      pat_ready_q <= 1'b0;
      dut_pi_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      mm_cnt_q    <= '0;
      pat_cnt_q   <= '0;
      ffp_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      pi_q        <= pi_d;
      si_q        <= si_d;
      exp_po_q    <= exp_po_d;
      po_mask_q   <= po_mask_d;
      last_q      <= last_d;
      pend_exp_q  <= pend_exp_d;
      pend_mask_q <= pend_mask_d;
      pend_vld_q  <= pend_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_mask_q  <= cmp_mask_d;
      cmp_vld_q   <= cmp_vld_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
      pat_ready_q <= pat_ready_d;
      dut_pi_q    <= dut_pi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      mm_cnt_q    <= mm_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      ffp_q       <= ffp_d;
    end
  end

  assign pat_ready      = pat_ready_q;
  assign scan_en        = scan_en_q;
  assign scan_in        = scan_in_q;
  assign dut_pi         = dut_pi_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign mismatch_cnt   = mm_cnt_q;
  assign pattern_cnt    = pat_cnt_q;
  assign first_fail_pat = ffp_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller: two instances (STOP_ON_FAIL 0/1) fed the same patterns,
// each driving a plain shift-register scan DUT with PO = PI.
module tb_scan_test_controller;

  localparam int unsigned CH  = 2;
  localparam int unsigned LN  = 4;
  localparam int unsigned PIW = 8;
  localparam int unsigned POW = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned SW  = CH * LN;
  localparam int          NP  = 3;

  logic           clk = 1'b0;
  logic           rst, start, pat_valid, pat_last;
  logic [PIW-1:0] pat_pi;
  logic [SW-1:0]  pat_si, pat_exp_so, pat_so_mask;
  logic [POW-1:0] pat_exp_po, pat_po_mask;

  logic           sen [2];
  logic [CH-1:0]  sin [2];
  logic [CH-1:0]  sout [2];
  logic [PIW-1:0] dpi [2];
  logic [POW-1:0] dpo [2];
  logic           rdy [2];
  logic           busy [2];
  logic           done [2];
  logic           fail [2];
  logic [CW-1:0]  mmc [2];
  logic [CW-1:0]  pc [2];
  logic [CW-1:0]  ffp [2];
  logic [LN-1:0]  chain [2][CH];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    scan_test_controller #(
      .CHAINS(CH), .LEN(LN), .PI_W(PIW), .PO_W(POW), .CNT_W(CW), .STOP_ON_FAIL(d == 1)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .pat_valid(pat_valid), .pat_ready(rdy[d]), .pat_last(pat_last),
      .pat_pi(pat_pi), .pat_si(pat_si), .pat_exp_po(pat_exp_po), .pat_po_mask(pat_po_mask),
      .pat_exp_so(pat_exp_so), .pat_so_mask(pat_so_mask),
      .scan_en(sen[d]), .scan_in(sin[d]), .scan_out(sout[d]),
      .dut_pi(dpi[d]), .dut_po(dpo[d]),
      .busy(busy[d]), .done(done[d]), .fail(fail[d]),
      .mismatch_cnt(mmc[d]), .pattern_cnt(pc[d]), .first_fail_pat(ffp[d])
    );
    for (genvar c = 0; c < CH; c++) begin : g_so
      assign sout[d][c] = chain[d][c][LN-1];
    end
    assign dpo[d] = dpi[d];
  end

  // Scan-inserted DUT model: flops shift head->tail when scan_en, otherwise hold
  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (!rst)        chain[d][c] <= '0;
        else if (sen[d]) chain[d][c] <= {chain[d][c][LN-2:0], sin[d][c]};
      end
    end
  end

  int busy_cyc0 = 0;
  int rdy_cyc1  = 0;
  always @(negedge clk) begin
    if (busy[0]) busy_cyc0++;
    if (rdy[1])  rdy_cyc1++;
  end

  typedef struct {
    logic fail0; logic [CW-1:0] mm0, pc0, ffp0; int cyc0; logic [PIW-1:0] pi;
    logic fail1; logic [CW-1:0] mm1, pc1, ffp1; int rdy1;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  logic [PIW-1:0] p_pi  [NP];
  logic [SW-1:0]  p_si  [NP];
  logic [SW-1:0]  p_eso [NP];
  logic [SW-1:0]  p_som [NP];
  logic [POW-1:0] p_epo [NP];
  logic [POW-1:0] p_pom [NP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic f0, input int m0, input int p0, input int ff0,
                              input int cyc, input logic f1, input int m1, input int p1,
                              input int ff1, input int r1);
    exp_t e;
    e.fail0 = f0; e.mm0 = CW'(m0); e.pc0 = CW'(p0); e.ffp0 = CW'(ff0); e.cyc0 = cyc;
    e.pi    = p_pi[NP-1];
    e.fail1 = f1; e.mm1 = CW'(m1); e.pc1 = CW'(p1); e.ffp1 = CW'(ff1); e.rdy1 = r1;
    return e;
  endfunction

  // Correct expectations: PO equals PI, and scan-out bit k of a chain is scan-in bit k
  task automatic gen_clean();
    for (int i = 0; i < NP; i++) begin
      p_pi[i]  = PIW'($urandom);
      p_si[i]  = SW'($urandom);
      p_epo[i] = p_pi[i];
      p_pom[i] = '1;
      p_eso[i] = p_si[i];
      p_som[i] = '1;
    end
  endtask

  task automatic present(input int i);
    pat_valid   = 1'b1;
    pat_last    = (i == NP - 1);
    pat_pi      = p_pi[i];
    pat_si      = p_si[i];
    pat_exp_po  = p_epo[i];
    pat_po_mask = p_pom[i];
    pat_exp_so  = p_eso[i];
    pat_so_mask = p_som[i];
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_cyc0 = 0;
    rdy_cyc1  = 0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!rdy[0] && t < 100) begin @(negedge clk); t++; end
    if (!rdy[0]) check("ready_timeout", 32'(rdy[0]), 32'd1);
  endtask

  task automatic accept();
    wait_ready();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ctl"}, 32'({sen[d], sin[d], dpi[d], rdy[d], busy[d], done[d], fail[d]}), 32'd0);
      check({tag, "_cnt"}, {mmc[d], pc[d]}, 32'd0);
      check({tag, "_ffp"}, 32'(ffp[d]), 32'd0);
    end
  endtask

  task automatic run_session(input int stall_pat, input exp_t e);
    exp_t r;
    int t = 0;
    sb.push_back(e);
    present(0);
    do_start();
    check("start_clr", {mmc[0], pc[0]}, 32'd0);
    check("start_flags", 32'({busy[0], done[0], fail[0]}), 32'b100);
    for (int i = 0; i < NP; i++) begin
      if (i > 0) present(i);
      if (i == stall_pat) begin
        pat_valid = 1'b0;
        wait_ready();
        for (int s = 0; s < 10; s++) begin
          check("stall_scan_en", 32'(sen[0]), 32'd0);
          check("stall_ready", 32'(rdy[0]), 32'd1);
          start = (s == 4);
          @(negedge clk);
        end
        start = 1'b0;
        present(i);
      end
      accept();
    end
    pat_valid = 1'b0;
    while (!done[0] && t < 200) begin @(negedge clk); t++; end
    check("done_timeout", 32'(done[0]), 32'd1);
    r = sb.pop_front();
    check("fail0", 32'(fail[0]), 32'(r.fail0));
    check("mismatch0", 32'(mmc[0]), 32'(r.mm0));
    check("patcnt0", 32'(pc[0]), 32'(r.pc0));
    check("firstfail0", 32'(ffp[0]), 32'(r.ffp0));
    check("busycyc0", 32'(busy_cyc0), 32'(r.cyc0));
    check("dut_pi0", 32'(dpi[0]), 32'(r.pi));
    check("busy0_end", 32'(busy[0]), 32'd0);
    check("fail1", 32'(fail[1]), 32'(r.fail1));
    check("mismatch1", 32'(mmc[1]), 32'(r.mm1));
    check("patcnt1", 32'(pc[1]), 32'(r.pc1));
    check("firstfail1", 32'(ffp[1]), 32'(r.ffp1));
    check("done1", 32'({done[1], busy[1]}), 32'b10);
    check("readycyc1", 32'(rdy_cyc1), 32'(r.rdy1));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
    pat_pi = '0; pat_si = '0; pat_exp_po = '0; pat_po_mask = '0;
    pat_exp_so = '0; pat_so_mask = '0;
    #12;
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    // clean run
    gen_clean();
    run_session(-1, mk(1'b0, 0, 3, 0, 22, 1'b0, 0, 3, 0, 3));

    // pattern 1 scan-out bit (c=1,k=2) wrong: seen while unloading during pattern 2 shift
    gen_clean();
    p_eso[1][6] = ~p_eso[1][6];
    run_session(-1, mk(1'b1, 1, 3, 1, 22, 1'b1, 1, 2, 1, 3));

    // same flipped bit, masked off
    gen_clean();
    p_eso[1][6] = ~p_eso[1][6];
    p_som[1][6] = 1'b0;
    run_session(-1, mk(1'b0, 0, 3, 0, 22, 1'b0, 0, 3, 0, 3));

    // two PO bits wrong in pattern 0's capture: one compare cycle; stop instance halts
    gen_clean();
    p_epo[0] = p_epo[0] ^ 8'h81;
    run_session(-1, mk(1'b1, 1, 3, 0, 22, 1'b1, 1, 1, 0, 1));

    // pattern 1 withheld 10 cycles with a start pulse while busy
    gen_clean();
    run_session(1, mk(1'b0, 0, 3, 0, 32, 1'b0, 0, 3, 0, 13));

    // reset mid-shift of pattern 1 after a PO failure
    gen_clean();
    p_epo[0] = p_epo[0] ^ 8'h03;
    present(0);
    do_start();
    accept();
    present(1);
    accept();
    pat_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_scan_en", 32'(sen[0]), 32'd1);
    check("pre_rst_cnt", {mmc[0], pc[0]}, {16'd1, 16'd1});
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk); #1 rst = 1'b1;

    // clean session after the abort
    gen_clean();
    run_session(-1, mk(1'b0, 0, 3, 0, 22, 1'b0, 0, 3, 0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/scan_test_controller.md
Name: scan_test_controller

Overview:
- Synthesizable, parametrised scan-test sequencer that replaces bench-driven scan stimulus with on-chip control.
- Drives a scan-inserted DUT with CHAINS parallel chains of LEN flops, and loads patterns over a valid/ready handshake.
- Overlaps shift-in of pattern n with shift-out of pattern n-1's response, and compares POs and scan-out against masked expected values.
- Reports pass/fail, mismatch count and first failing pattern to the test host.

Parameters:
CHAINS, 4, number of parallel scan chains (>=1)
LEN, 16, flops per chain / shift cycles per pattern (>=2)
PI_W, 17, DUT primary-input width
PO_W, 27, DUT primary-output width
CNT_W, 16, width of the pattern and mismatch counters
STOP_ON_FAIL, 0, 1 = terminate at end of the first failing compare cycle

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  begin test session (sampled in IDLE only)
pat_valid  in  1  pattern word valid
pat_ready  out  1  controller accepts pattern
pat_last  in  1  this pattern is the final one
pat_pi  in  PI_W  PI values applied during capture
pat_si  in  CHAINS*LEN  scan-in bits; bit c*LEN+k is shifted on chain c in shift cycle k
pat_exp_po  in  PO_W  expected POs at capture
pat_po_mask  in  PO_W  1 = compare PO bit
pat_exp_so  in  CHAINS*LEN  expected scan-out of this pattern's captured response
pat_so_mask  in  CHAINS*LEN  1 = compare scan-out bit
scan_en  out  1  1 = shift, 0 = functional/capture
scan_in  out  CHAINS  serial data to chain heads
scan_out  in  CHAINS  serial data from chain tails
dut_pi  out  PI_W  DUT primary inputs
dut_po  in  PO_W  DUT primary outputs
busy  out  1  session in progress
done  out  1  session finished; held until next start
fail  out  1  at least one mismatch (sticky per session)
mismatch_cnt  out  CNT_W  compare cycles with any mismatch, saturating
pattern_cnt  out  CNT_W  patterns captured
first_fail_pat  out  CNT_W  pattern index of the first failure (0 if none)

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs are 0: scan_en, scan_in, dut_pi, pat_ready, busy, done, fail, and all counters.
  - Reset mid-session aborts the session with no completion reported.
- IDLE:
  - On start=1: clear fail, done and all counters; set busy=1; go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - pat_ready=1 and scan_en=0.
  - On pat_valid&pat_ready: latch pi, si, exp_po, po_mask and last into the current slot; latch exp_so and so_mask into the pending slot; go to SHIFT with k=0.
  - The previous pending slot moves to the compare slot at that same edge.
- SHIFT (LEN cycles):
  - scan_en=1 and scan_in[c]=si[c*LEN+k].
  - At each rising edge, sample scan_out[c] and compare it to compare-slot exp_so[c*LEN+k] wherever so_mask=1.
  - The first session pattern has no valid compare slot, so scan-out compare is disabled for it.
  - After k=LEN-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - scan_en=0 and dut_pi=pi; dut_pi holds its value until the next capture.
  - At the edge, compare dut_po to exp_po where po_mask=1, and increment pattern_cnt.
  - Next state is FLUSH if last=1, otherwise LOAD.
- FLUSH (LEN cycles):
  - scan_en=1 and scan_in=0.
  - The final pending slot is moved to the compare slot on entry, then compared as in SHIFT.
  - Then go to DONE.
- DONE:
  - busy=0 and done=1; return to IDLE (done stays 1 until the next start).
- Compare cycle definition: one SHIFT/FLUSH edge, or one CAPTURE edge.
  - A mismatch on any unmasked bit of that cycle increments mismatch_cnt by 1, saturating at all-ones, and sets fail.
  - On the first mismatch, first_fail_pat is loaded with the index of the pattern whose response failed. That index is pattern_cnt-1 for scan-out compare and the current pattern index for PO compare.
- STOP_ON_FAIL=1: after the first failing compare cycle, go directly to DONE; remaining patterns are not requested.
- pat_ready is 1 only in LOAD; the bench may hold pat_valid indefinitely.

Test Plan:
- CHAINS=2, LEN=4; DUT model = plain shift register with PO=PI pass-through; 3 patterns with correct expectations -> done after 3*(1+4+1)+4 active cycles; fail=0, mismatch_cnt=0, pattern_cnt=3.
- Same setup, pattern 1 exp_so bit c=1,k=2 flipped -> fail=1, mismatch_cnt=1, first_fail_pat=1; flipping the same bit with so_mask=0 -> fail=0.
- PO mismatch on pattern 0 in two bits in the same capture -> mismatch_cnt=1 (per cycle, not per bit), first_fail_pat=0.
- STOP_ON_FAIL=1 with a failure in pattern 0's PO -> DONE follows capture; pat_ready never reasserts; pattern_cnt=1.
- rst=0 asserted mid-SHIFT -> all outputs 0 immediately; start afterwards begins a clean session with counters 0.
- pat_valid withheld 10 cycles in LOAD, and start pulsed while busy -> scan_en stays 0 during the wait, no state change from start, and results identical to the unstalled run.
